// File: rtl/tpu_pkg.sv
// tpu_pkg: shared operand widths, array size and FSM state type for the tpumac datapath.
package tpu_pkg;
    localparam int BITS_AB = 8;
    localparam int BITS_C = 32;
    localparam int DIM = 8;
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    typedef logic signed [BITS_AB-1:0] elem_t;
endpackage

// File: rtl/skew_row.sv
// skew_row: one stored matrix row, emitting element k-ROW_IDX inside its window and 0 outside.
module skew_row #(
    parameter int BITS_AB = tpu_pkg::BITS_AB,
    parameter int DIM = tpu_pkg::DIM,
    parameter int ROW_IDX = 0
) (
    input logic clk,
    input logic rst_n,
    input logic we,
    input logic [DIM*BITS_AB-1:0] din,
    input logic [$clog2(2*DIM)-1:0] k,
    output logic [BITS_AB-1:0] a
);
    import tpu_pkg::*;
    localparam int KW = $clog2(2*DIM);
    localparam int AW = $clog2(DIM);
    logic [BITS_AB-1:0] row [DIM];
    logic [KW-1:0] off;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int i = 0; i < DIM; i++) row[i] <= '0;
        else if (we) for (int i = 0; i < DIM; i++) row[i] <= din[i*BITS_AB +: BITS_AB];
    end
    assign off = k - KW'(ROW_IDX);
    // zero outside the window keeps the accumulating MACs clean
    assign a = (k >= KW'(ROW_IDX) && off < KW'(DIM)) ? row[off[AW-1:0]] : '0;
endmodule

// File: rtl/skew_feeder.sv
// skew_feeder: streams a DIM x DIM operand matrix into the systolic A edge with row r delayed r cycles.
// Optional SKEW_FEEDER_WR_GUARD_EN drops loads while busy and raises sticky wr_err.
module skew_feeder #(
    parameter int BITS_AB = tpu_pkg::BITS_AB,
    parameter int DIM = tpu_pkg::DIM
) (
    input logic clk,
    input logic rst_n,
    input logic WrEn,
    input logic [$clog2(DIM)-1:0] Arow,
    input logic [DIM*BITS_AB-1:0] Ain,
    input logic start,
    output logic [DIM*BITS_AB-1:0] Aout,
    output logic mac_en,
    output logic busy,
    output logic done,
    output logic wr_err
);
    import tpu_pkg::*;
    localparam int KW = $clog2(2*DIM);
    localparam int AW = $clog2(DIM);
    localparam int LAST = 2*DIM-2;
    state_t state, state_n;
    logic [KW-1:0] k, k_n;
    logic [DIM*BITS_AB-1:0] lanes, aout_n;
    logic wr_ok;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = (state == IDLE) ? ((start && !WrEn) ? STREAM : IDLE) :
                  (state == STREAM) ? ((k == KW'(LAST)) ? DONE : STREAM) : IDLE;
    end
    // rows see the upcoming k so the registered Aout lines up with mac_en
    always_comb begin
        k_n = (state == STREAM) ? k + 1'b1 : '0;
        aout_n = (state_n == STREAM) ? lanes : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
            Aout <= '0;
            mac_en <= 1'b0;
            done <= 1'b0;
        end else begin
            k <= (state_n == STREAM) ? k_n : '0;
            Aout <= aout_n;
            mac_en <= state_n == STREAM;
            done <= state_n == DONE;
        end
    end
    assign busy = state != IDLE;
    for (genvar r = 0; r < DIM; r++) begin : g_row
        skew_row #(.BITS_AB(BITS_AB), .DIM(DIM), .ROW_IDX(r)) u_row (
            .clk(clk),
            .rst_n(rst_n),
            .we(wr_ok && Arow == AW'(r)),
            .din(Ain),
            .k(k_n),
            .a(lanes[r*BITS_AB +: BITS_AB])
        );
    end
`ifdef SKEW_FEEDER_WR_GUARD_EN
    assign wr_ok = WrEn && !busy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_err <= 1'b0;
        else if (WrEn && busy) wr_err <= 1'b1;
    end
`else
    assign wr_ok = WrEn;
    assign wr_err = 1'b0;
`endif
endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: table vectors, corner sequences and random loads against a matrix reference model.
module tb_skew_feeder;
    localparam int BW = 8;
    localparam int DIM = 4;
    localparam int DW = DIM*BW;
    localparam int NK = 2*DIM-1;
`ifdef SKEW_FEEDER_WR_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic WrEn = 1'b0;
    logic start = 1'b0;
    logic [1:0] Arow = '0;
    logic [DW-1:0] Ain = '0;
    logic [DW-1:0] Aout;
    logic mac_en, busy, done, wr_err;
    int errors = 0;
    int checks = 0;
    logic [BW-1:0] mem [DIM][DIM];
    logic [DW-1:0] cap [NK];
    typedef struct {
        int k;
        logic [DW-1:0] exp;
        string nm;
    } vec_t;
    vec_t tbl [5];
    logic [BW-1:0] sgn [4];

    skew_feeder #(.BITS_AB(BW), .DIM(DIM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .WrEn(WrEn),
        .Arow(Arow),
        .Ain(Ain),
        .start(start),
        .Aout(Aout),
        .mac_en(mac_en),
        .busy(busy),
        .done(done),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mem_clear();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) mem[r][c] = '0;
    endtask

    function automatic logic [DW-1:0] exp_aout(input int k);
        logic [DW-1:0] v;
        v = '0;
        for (int r = 0; r < DIM; r++)
            if (k - r >= 0 && k - r < DIM) v[r*BW +: BW] = mem[r][k-r];
        return v;
    endfunction

    function automatic logic [DW-1:0] pack16(input int r);
        logic [DW-1:0] v;
        for (int c = 0; c < DIM; c++) v[c*BW +: BW] = BW'(16*r + c);
        return v;
    endfunction

    task automatic load_row(input int r, input logic [DW-1:0] d);
        WrEn = 1'b1;
        Arow = 2'(r);
        Ain = d;
        tick();
        WrEn = 1'b0;
        Ain = $urandom();
        for (int c = 0; c < DIM; c++) mem[r][c] = d[c*BW +: BW];
    endtask

    task automatic run_stream(input string nm, input bit poke_start, input bit wr_mid, input logic [DW-1:0] wdata);
        int n;
        bit data_ok;
        n = 0;
        data_ok = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NK; k++) begin
            cap[k] = Aout;
            if (mac_en) n++;
            chk($sformatf("%s busy k%0d", nm, k), busy, 1);
            chk($sformatf("%s done k%0d", nm, k), done, 0);
            if (data_ok) chk($sformatf("%s aout k%0d", nm, k), Aout, exp_aout(k));
            if (poke_start && k == 3) start = 1'b1;
            if (wr_mid && k == 2) begin
                WrEn = 1'b1;
                Arow = 2'd1;
                Ain = wdata;
            end
            tick();
            start = 1'b0;
            WrEn = 1'b0;
            if (wr_mid && k == 2 && !GUARD) begin
                for (int c = 0; c < DIM; c++) mem[1][c] = wdata[c*BW +: BW];
                data_ok = 1'b0;
            end
        end
        chk({nm, " mac_en count"}, n, NK);
        chk({nm, " end mac_en"}, mac_en, 0);
        chk({nm, " end aout"}, Aout, 0);
        chk({nm, " done pulse"}, done, 1);
        chk({nm, " done busy"}, busy, 1);
        tick();
        chk({nm, " idle done"}, done, 0);
        chk({nm, " idle busy"}, busy, 0);
    endtask

    initial begin
        tbl[0] = '{k: 0, exp: 32'h00000000, nm: "skew k0"};
        tbl[1] = '{k: 1, exp: 32'h00001001, nm: "skew k1"};
        tbl[2] = '{k: 3, exp: 32'h30211203, nm: "skew k3"};
        tbl[3] = '{k: 4, exp: 32'h31221300, nm: "skew k4"};
        tbl[4] = '{k: 6, exp: 32'h33000000, nm: "skew k6"};
        sgn[0] = 8'h80;
        sgn[1] = 8'h7F;
        sgn[2] = 8'hFF;
        sgn[3] = 8'h00;
        mem_clear();
        repeat (3) tick();
        chk("rst aout", Aout, 0);
        chk("rst mac_en", mac_en, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst wr_err", wr_err, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("idle rst aout", Aout, 0);
        chk("idle rst busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_stream("zero", 1'b0, 1'b0, '0);

        for (int r = 0; r < DIM; r++) load_row(r, pack16(r));
        run_stream("skew", 1'b0, 1'b0, '0);
        foreach (tbl[i]) chk(tbl[i].nm, cap[tbl[i].k], tbl[i].exp);

        load_row(0, 32'h00FF7F80);
        run_stream("signed", 1'b0, 1'b0, '0);
        for (int k = 0; k < 4; k++) chk($sformatf("signed lane0 k%0d", k), cap[k][BW-1:0], sgn[k]);

        WrEn = 1'b1;
        Arow = 2'd2;
        Ain = 32'hA5C3_0F96;
        start = 1'b1;
        tick();
        WrEn = 1'b0;
        start = 1'b0;
        for (int c = 0; c < DIM; c++) mem[2][c] = Ain[c*BW +: BW];
        chk("collide busy", busy, 0);
        chk("collide mac_en", mac_en, 0);
        tick();
        chk("collide still idle", busy, 0);
        run_stream("collide", 1'b0, 1'b0, '0);

        run_stream("restart", 1'b1, 1'b0, '0);

        run_stream("guard", 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("guard wr_err", wr_err, GUARD);
        run_stream("post guard", 1'b0, 1'b0, '0);
        chk("guard wr_err sticky", wr_err, GUARD);

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("midrst k4 mac_en", mac_en, 1);
        chk("midrst k4 aout", Aout, exp_aout(4));
        rst_n = 1'b0;
        #1;
        chk("midrst aout", Aout, 0);
        chk("midrst mac_en", mac_en, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst wr_err", wr_err, 0);
        mem_clear();
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst idle", busy, 0);
        for (int r = 0; r < DIM; r++) load_row(r, {DIM{8'h05}});
        run_stream("fives", 1'b0, 1'b0, '0);

        for (int it = 0; it < 12; it++) begin
            for (int r = 0; r < DIM; r++)
                if ($urandom_range(0, 1) == 1) load_row(r, $urandom());
            repeat ($urandom_range(0, 2)) tick();
            run_stream($sformatf("rand%0d", it), 1'($urandom_range(0, 1)), 1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
